dc_exp_sequencer: RTL and testbench
===================================

Name: dc_exp_sequencer

Overview:
- Consumer end of the dcache exception interface; takes the read-operand stage's dc_exp / dc_prot_exp / dc_page_fault and the external interrupt request.
- Sequences exception entry: stall fetch, drain, flush, hand a vector to fetch, then hold isr until the handler's IRET retires.
- Drives isr back to the read-operand exception checker, which masks protection checks while in a handler.
- Captures the faulting EIP and the page-fault linear address (CR2).

Parameters:
- INT_VECTOR, 8'h20, vector issued for ext_int.
- DRAIN_TIMEOUT, 16, max cycles in DRAIN before a forced flush (2..255).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- v_ro_valid  in  1  read-operand stage holds a valid instruction
- dc_exp  in  1  any dcache exception this cycle
- dc_prot_exp  in  1  segment-limit/RW protection exception
- dc_page_fault  in  1  TLB miss/not-present fault
- ro_eip  in  32  EIP of the instruction in read-operand
- ro_fault_addr  in  32  faulting linear address (rd or wr, pre-muxed)
- ext_int  in  1  level interrupt request, held by source until serviced
- pipe_empty  in  1  all stages younger than read-operand are empty
- vector_ack  in  1  fetch accepted the vector
- iret_done  in  1  IRET retired
- fetch_stall  out  1  stall fetch/decode
- flush  out  1  one-cycle pipeline flush
- vector_valid  out  1  vector presented to fetch
- vector  out  8  exception/interrupt vector
- isr  out  1  in-handler flag
- saved_eip  out  32  EIP to push
- cr2  out  32  last page-fault address
- halt  out  1  shutdown (feature only)

Behaviour:
- Reset (async, any state): state IDLE, drain counter 0, all outputs 0, including cr2, saved_eip and vector.
- Request qualification: exp_req = dc_exp & v_ro_valid.
- Vector priority: dc_prot_exp → 8'h0D; else dc_page_fault → 8'h0E; else dc_exp alone → 8'h0D.
- ext_int is accepted only in IDLE when exp_req=0; it loads INT_VECTOR and saved_eip=ro_eip.
- Exceptions win over ext_int in the same cycle; the interrupt remains pending because it is level-held.
- States:
  - IDLE: on exp_req or ext_int, latch vector and saved_eip. Load cr2 only for page-fault vector 0x0E, otherwise cr2 holds. Clear counter, go to DRAIN next cycle.
  - DRAIN: fetch_stall=1; counter increments. Exit to FLUSH on pipe_empty, or when counter==DRAIN_TIMEOUT-1, whichever comes first.
  - FLUSH: flush=1 and fetch_stall=1 for exactly one cycle, then DISPATCH.
  - DISPATCH: vector_valid=1 and fetch_stall=1.
    - vector, vector_valid and saved_eip stay stable until vector_ack.
    - On the ack cycle, move to IN_ISR; vector_valid drops the next cycle.
  - IN_ISR: isr=1 and fetch_stall=0. On iret_done, return to IDLE with isr=0 the next cycle.
- Latency: request in cycle t → fetch_stall at t+1; with pipe_empty=1 at t+1, flush at t+2 and vector_valid from t+3.
- While in IN_ISR, ext_int is ignored.
- While in IN_ISR without the feature, exp_req is ignored. If iret_done and exp_req coincide, iret_done wins and the fault is dropped; the instruction re-faults when it re-executes.
- New requests in DRAIN, FLUSH or DISPATCH are ignored; latched values hold.
- vector_ack outside DISPATCH is ignored.

Optional Feature:
- Macro: DC_DOUBLE_FAULT_EN.
- With the macro:
  - exp_req in IN_ISR (iret_done=0) loads vector 8'h08, sets a double-fault flag and re-enters DRAIN with isr held at 1. cr2 still updates on a page fault.
  - exp_req in IN_ISR while the flag is set enters HALT. In HALT: halt=1, fetch_stall=1, no exit except rst.
  - iret_done clears the flag.
- Without the macro: no HALT state, halt is tied 0, and faults in IN_ISR are dropped.

Test Plan:
- Page fault: v_ro_valid=1, dc_exp=1, dc_page_fault=1, ro_eip=0x1000, ro_fault_addr=0xDEAD0123, pipe_empty=1 → flush at t+2; vector=0x0E and vector_valid from t+3; saved_eip=0x1000; cr2=0xDEAD0123; vector_ack → isr=1; iret_done → IDLE, isr=0.
- Priority: dc_prot_exp=1, dc_page_fault=1, ext_int=1 in the same cycle → vector=0x0D, cr2 unchanged. After IRET with ext_int still high → second entry with vector=0x20.
- Drain timeout: request with pipe_empty held 0 → flush asserted exactly DRAIN_TIMEOUT cycles after DRAIN entry (16 cycles at default).
- Ack hold: delay vector_ack by 5 cycles while toggling dc_exp → vector, vector_valid and saved_eip stable throughout, no re-entry.
- Reset mid-DISPATCH: assert rst asynchronously between clock edges → all outputs 0 immediately; after release, state IDLE.
- DC_DOUBLE_FAULT_EN: page fault in IN_ISR → vector=0x08 with isr held 1; a second fault before iret_done → halt=1. Without the macro, the same stimulus produces no change.

Source files
------------

// File: rtl/dc_exp_sequencer.sv
// Exception/interrupt entry sequencer on the consumer side of the dcache exception interface.
// Optional double-fault/shutdown handling is enabled by defining DC_DOUBLE_FAULT_EN.
module dc_exp_sequencer #(
  parameter logic [7:0] INT_VECTOR    = 8'h20,
  parameter int         DRAIN_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        v_ro_valid,
  input  logic        dc_exp,
  input  logic        dc_prot_exp,
  input  logic        dc_page_fault,
  input  logic [31:0] ro_eip,
  input  logic [31:0] ro_fault_addr,
  input  logic        ext_int,
  input  logic        pipe_empty,
  input  logic        vector_ack,
  input  logic        iret_done,
  output logic        fetch_stall,
  output logic        flush,
  output logic        vector_valid,
  output logic [7:0]  vector,
  output logic        isr,
  output logic [31:0] saved_eip,
  output logic [31:0] cr2,
  output logic        halt
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DRAIN    = 3'd1;
  localparam logic [2:0] FLUSH    = 3'd2;
  localparam logic [2:0] DISPATCH = 3'd3;
  localparam logic [2:0] IN_ISR   = 3'd4;
`ifdef DC_DOUBLE_FAULT_EN
  localparam logic [2:0] HALT     = 3'd5;
`endif

  localparam logic [7:0] VEC_GP  = 8'h0D;
  localparam logic [7:0] VEC_PF  = 8'h0E;
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  vector_q, vector_d;
  logic [31:0] saved_eip_q, saved_eip_d;
  logic [31:0] cr2_q, cr2_d;
`ifdef DC_DOUBLE_FAULT_EN
  logic        dflt_q, dflt_d;
`endif

  logic       expReq;
  logic [7:0] excVector;

  assign expReq    = dc_exp & v_ro_valid;
  assign excVector = dc_prot_exp ? VEC_GP : (dc_page_fault ? VEC_PF : VEC_GP);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vector_d    = vector_q;
    saved_eip_d = saved_eip_q;
    cr2_d       = cr2_q;
`ifdef DC_DOUBLE_FAULT_EN
    dflt_d      = dflt_q;
`endif
    case (state_q)
      IDLE: begin
        // Exceptions beat a simultaneous interrupt; the level-held ext_int is taken later.
        if (expReq) begin
          vector_d    = excVector;
          saved_eip_d = ro_eip;
          if (excVector == VEC_PF) cr2_d = ro_fault_addr;
          cnt_d       = 8'd0;
          state_d     = DRAIN;
        end else if (ext_int) begin
          vector_d    = INT_VECTOR;
          saved_eip_d = ro_eip;
          cnt_d       = 8'd0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (pipe_empty || cnt_q == DRAIN_LAST) state_d = FLUSH;
      end
      FLUSH: state_d = DISPATCH;
      DISPATCH: begin
        if (vector_ack) state_d = IN_ISR;
      end
      IN_ISR: begin
        if (iret_done) begin
          state_d = IDLE;
`ifdef DC_DOUBLE_FAULT_EN
          dflt_d  = 1'b0;
        end else if (expReq) begin
          if (dflt_q) begin
            state_d = HALT;
          end else begin
            vector_d    = 8'h08;
            saved_eip_d = ro_eip;
            if (excVector == VEC_PF) cr2_d = ro_fault_addr;
            dflt_d      = 1'b1;
            cnt_d       = 8'd0;
            state_d     = DRAIN;
          end
`endif
        end
      end
`ifdef DC_DOUBLE_FAULT_EN
      HALT: state_d = HALT;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      vector_q    <= 8'd0;
      saved_eip_q <= 32'd0;
      cr2_q       <= 32'd0;
`ifdef DC_DOUBLE_FAULT_EN
      dflt_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vector_q    <= vector_d;
      saved_eip_q <= saved_eip_d;
      cr2_q       <= cr2_d;
`ifdef DC_DOUBLE_FAULT_EN
      dflt_q      <= dflt_d;
`endif
    end
  end

  assign flush        = (state_q == FLUSH);
  assign vector_valid = (state_q == DISPATCH);
  assign vector       = vector_q;
  assign saved_eip    = saved_eip_q;
  assign cr2          = cr2_q;

`ifdef DC_DOUBLE_FAULT_EN
  // A nested fault keeps the handler flag up while the double-fault entry is sequenced.
  assign fetch_stall = (state_q == DRAIN) || (state_q == FLUSH) ||
                       (state_q == DISPATCH) || (state_q == HALT);
  assign isr         = (state_q == IN_ISR) || dflt_q;
  assign halt        = (state_q == HALT);
`else
  assign fetch_stall = (state_q == DRAIN) || (state_q == FLUSH) || (state_q == DISPATCH);
  assign isr         = (state_q == IN_ISR);
  assign halt        = 1'b0;
`endif

endmodule

// File: tb/tb_dc_exp_sequencer.sv
// Directed-vector bench for dc_exp_sequencer: entry latency, priority, drain timeout,
// ack hold, asynchronous reset and nested faults (both DC_DOUBLE_FAULT_EN builds).
module tb_dc_exp_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v_ro_valid = 1'b0;
  logic        dc_exp = 1'b0;
  logic        dc_prot_exp = 1'b0;
  logic        dc_page_fault = 1'b0;
  logic [31:0] ro_eip = 32'd0;
  logic [31:0] ro_fault_addr = 32'd0;
  logic        ext_int = 1'b0;
  logic        pipe_empty = 1'b1;
  logic        vector_ack = 1'b0;
  logic        iret_done = 1'b0;
  logic        fetch_stall, flush, vector_valid, isr, halt;
  logic [7:0]  vector;
  logic [31:0] saved_eip, cr2;

  int vectorCount = 0;
  int miscompares = 0;

  dc_exp_sequencer dut (
    .clk(clk), .rst(rst), .v_ro_valid(v_ro_valid), .dc_exp(dc_exp),
    .dc_prot_exp(dc_prot_exp), .dc_page_fault(dc_page_fault), .ro_eip(ro_eip),
    .ro_fault_addr(ro_fault_addr), .ext_int(ext_int), .pipe_empty(pipe_empty),
    .vector_ack(vector_ack), .iret_done(iret_done), .fetch_stall(fetch_stall),
    .flush(flush), .vector_valid(vector_valid), .vector(vector), .isr(isr),
    .saved_eip(saved_eip), .cr2(cr2), .halt(halt)
  );

  always #5 clk = ~clk;

  // Advance one cycle and land just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic exp, input logic prot, input logic pf,
                               input logic [31:0] eip, input logic [31:0] addr);
    v_ro_valid    = 1'b1;
    dc_exp        = exp;
    dc_prot_exp   = prot;
    dc_page_fault = pf;
    ro_eip        = eip;
    ro_fault_addr = addr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectorCount++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_stall"}, {31'd0, fetch_stall}, 32'd0);
    checkOutput({tag, "_flush"}, {31'd0, flush}, 32'd0);
    checkOutput({tag, "_vvalid"}, {31'd0, vector_valid}, 32'd0);
    checkOutput({tag, "_isr"}, {31'd0, isr}, 32'd0);
    checkOutput({tag, "_halt"}, {31'd0, halt}, 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    checkQuiet("rst");
    checkOutput("rst_vector", {24'd0, vector}, 32'd0);
    checkOutput("rst_eip", saved_eip, 32'd0);
    checkOutput("rst_cr2", cr2, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Page fault entry and latency
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1000, 32'hDEAD0123);
    tick();
    checkOutput("pf_t1_stall", {31'd0, fetch_stall}, 32'd1);
    checkOutput("pf_t1_flush", {31'd0, flush}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h1004, 32'h0);
    tick();
    checkOutput("pf_t2_flush", {31'd0, flush}, 32'd1);
    checkOutput("pf_t2_vvalid", {31'd0, vector_valid}, 32'd0);
    tick();
    checkOutput("pf_t3_vvalid", {31'd0, vector_valid}, 32'd1);
    checkOutput("pf_t3_flush", {31'd0, flush}, 32'd0);
    checkOutput("pf_vector", {24'd0, vector}, 32'h0E);
    checkOutput("pf_eip", saved_eip, 32'h1000);
    checkOutput("pf_cr2", cr2, 32'hDEAD0123);
    vector_ack = 1'b1;
    tick();
    vector_ack = 1'b0;
    checkOutput("pf_isr", {31'd0, isr}, 32'd1);
    checkOutput("pf_isr_stall", {31'd0, fetch_stall}, 32'd0);
    checkOutput("pf_isr_vvalid", {31'd0, vector_valid}, 32'd0);
    iret_done = 1'b1;
    tick();
    iret_done = 1'b0;
    checkQuiet("pf_iret");

    // Priority: protection beats page fault beats ext_int
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h2000, 32'h11110000);
    ext_int = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h2004, 32'h0);
    tick();
    tick();
    checkOutput("pri_vector", {24'd0, vector}, 32'h0D);
    checkOutput("pri_cr2", cr2, 32'hDEAD0123);
    checkOutput("pri_eip", saved_eip, 32'h2000);
    vector_ack = 1'b1;
    tick();
    vector_ack = 1'b0;
    tick();
    checkOutput("pri_intignored_isr", {31'd0, isr}, 32'd1);
    checkOutput("pri_intignored_stall", {31'd0, fetch_stall}, 32'd0);
    ro_eip = 32'h3000;
    iret_done = 1'b1;
    tick();
    iret_done = 1'b0;
    checkOutput("pri_idle_isr", {31'd0, isr}, 32'd0);
    tick();
    ext_int = 1'b0;
    checkOutput("int_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    tick();
    checkOutput("int_vvalid", {31'd0, vector_valid}, 32'd1);
    checkOutput("int_vector", {24'd0, vector}, 32'h20);
    checkOutput("int_eip", saved_eip, 32'h3000);
    checkOutput("int_cr2", cr2, 32'hDEAD0123);
    vector_ack = 1'b1;
    tick();
    vector_ack = 1'b0;
    iret_done = 1'b1;
    tick();
    iret_done = 1'b0;
    checkQuiet("int_iret");

    // Drain timeout: flush exactly 16 cycles after DRAIN entry
    pipe_empty = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h4000, 32'h55550000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h4004, 32'h0);
    checkOutput("to_entry_stall", {31'd0, fetch_stall}, 32'd1);
    for (int i = 1; i < 16; i++) begin
      tick();
      checkOutput("to_noflush", {31'd0, flush}, 32'd0);
    end
    tick();
    checkOutput("to_flush", {31'd0, flush}, 32'd1);
    checkOutput("to_vector", {24'd0, vector}, 32'h0D);
    checkOutput("to_cr2", cr2, 32'hDEAD0123);
    pipe_empty = 1'b1;

    // Ack hold while dc_exp toggles
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b1, 32'h4100 + 32'(i), 32'h77770000);
      tick();
      checkOutput("hold_vvalid", {31'd0, vector_valid}, 32'd1);
      checkOutput("hold_vector", {24'd0, vector}, 32'h0D);
      checkOutput("hold_eip", saved_eip, 32'h4000);
      checkOutput("hold_cr2", cr2, 32'hDEAD0123);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    vector_ack = 1'b1;
    tick();
    vector_ack = 1'b0;
    checkOutput("hold_isr", {31'd0, isr}, 32'd1);
    iret_done = 1'b1;
    tick();
    iret_done = 1'b0;
    checkQuiet("hold_iret");

    // Asynchronous reset mid-DISPATCH
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h6000, 32'hABCD0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("ar_pre_vvalid", {31'd0, vector_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkQuiet("ar");
    checkOutput("ar_vector", {24'd0, vector}, 32'd0);
    checkOutput("ar_eip", saved_eip, 32'd0);
    checkOutput("ar_cr2", cr2, 32'd0);
    #1;
    rst = 1'b0;
    tick();
    checkQuiet("ar_idle");

    // Nested fault inside the handler
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h5000, 32'hCAFE0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    vector_ack = 1'b1;
    tick();
    vector_ack = 1'b0;
    checkOutput("df_isr", {31'd0, isr}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h5004, 32'hBEEF0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef DC_DOUBLE_FAULT_EN
    checkOutput("df_stall", {31'd0, fetch_stall}, 32'd1);
    checkOutput("df_isr_held", {31'd0, isr}, 32'd1);
    checkOutput("df_cr2", cr2, 32'hBEEF0000);
    tick();
    tick();
    checkOutput("df_vector", {24'd0, vector}, 32'h08);
    checkOutput("df_vvalid", {31'd0, vector_valid}, 32'd1);
    checkOutput("df_dispatch_isr", {31'd0, isr}, 32'd1);
    vector_ack = 1'b1;
    tick();
    vector_ack = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h5008, 32'h12340000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("df_halt", {31'd0, halt}, 32'd1);
    checkOutput("df_halt_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    checkOutput("df_halt_stays", {31'd0, halt}, 32'd1);
`else
    checkOutput("df_stall", {31'd0, fetch_stall}, 32'd0);
    checkOutput("df_isr_held", {31'd0, isr}, 32'd1);
    checkOutput("df_cr2", cr2, 32'hCAFE0000);
    checkOutput("df_vector", {24'd0, vector}, 32'h0E);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h5008, 32'h12340000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("df_halt", {31'd0, halt}, 32'd0);
    checkOutput("df_isr_still", {31'd0, isr}, 32'd1);
    checkOutput("df_cr2_still", cr2, 32'hCAFE0000);
    iret_done = 1'b1;
    tick();
    iret_done = 1'b0;
    checkQuiet("df_iret");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

endmodule
